// File: rtl/concat_stream_ctrl_pkg.sv
// Shared definitions for the channel-concat stream controller: FSM states and the done/ack code.
package concat_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStream0,
    StStream1,
    StFlush,
    StDone
  } state_e;

  localparam logic [3:0] DoneCodeDefault = 4'hF;

endpackage

// File: rtl/concat_stream_ctrl_stream_reg_slice.sv
// One-entry valid/ready output register; accepts a new beat in the same cycle the old one drains.
module concat_stream_ctrl_stream_reg_slice #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/concat_stream_ctrl.sv
// Channel-concat sequencer: per pixel forwards ch0 beats from S_Data then ch1 beats from S_Data_1,
// pulses the DMA starts on load and raises a done code until the host acknowledges it.
module concat_stream_ctrl
  import concat_stream_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned PIX_W     = 24,
  parameter logic [3:0]  DONE_CODE = DoneCodeDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_ch0_beats,
  input  logic [CNT_W-1:0]  cfg_ch1_beats,
  input  logic [CNT_W-1:0]  cfg_height,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [7:0]        Control_RE,
  output logic [7:0]        State_RE,
  output logic              DMA_Read_Start,
  output logic              DMA_Read_Start_2,
  output logic              DMA_Write_Start,
  input  logic [DATA_W-1:0] S_Data,
  input  logic              S_Valid,
  output logic              S_Ready,
  input  logic [DATA_W-1:0] S_Data_1,
  input  logic              S_Valid_1,
  output logic              S_Ready_1,
  output logic [DATA_W-1:0] M_Data,
  output logic              M_Valid,
  input  logic              M_Ready
);

  state_e             state_q;
  logic [CNT_W-1:0]   ch0_q, ch1_q, beat_cnt_q;
  logic [PIX_W-1:0]   pix_total_q, pix_cnt_q;
  logic               done_q, dma_q;
  logic               load_ok, in_valid, in_fire, last_beat, last_pix;
  logic [DATA_W-1:0]  in_data;
  logic [PIX_W-1:0]   pix_total_d;
  logic               unused_ctrl;

  assign unused_ctrl = ^Control_RE[7:4];
  assign pix_total_d = PIX_W'(cfg_height) * PIX_W'(cfg_width);

  assign S_Ready   = (state_q == StStream0) && load_ok;
  assign S_Ready_1 = (state_q == StStream1) && load_ok;
  assign in_valid  = ((state_q == StStream0) && S_Valid) || ((state_q == StStream1) && S_Valid_1);
  assign in_data   = (state_q == StStream1) ? S_Data_1 : S_Data;
  assign in_fire   = in_valid && load_ok;

  assign last_beat = (state_q == StStream1) ? (beat_cnt_q == ch1_q - CNT_W'(1))
                                            : (beat_cnt_q == ch0_q - CNT_W'(1));
  assign last_pix  = (pix_cnt_q == pix_total_q - PIX_W'(1));

  assign State_RE         = {4'h0, done_q ? DONE_CODE : 4'h0};
  assign DMA_Read_Start   = dma_q;
  assign DMA_Read_Start_2 = dma_q;
  assign DMA_Write_Start  = dma_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ch0_q       <= '0;
      ch1_q       <= '0;
      beat_cnt_q  <= '0;
      pix_total_q <= '0;
      pix_cnt_q   <= '0;
      done_q      <= 1'b0;
      dma_q       <= 1'b0;
    end else begin
      dma_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            dma_q   <= 1'b1;
          end
        end
        StLoad: begin
          ch0_q       <= cfg_ch0_beats;
          ch1_q       <= cfg_ch1_beats;
          pix_total_q <= pix_total_d;
          beat_cnt_q  <= '0;
          pix_cnt_q   <= '0;
          if (pix_total_d == '0 || (cfg_ch0_beats == '0 && cfg_ch1_beats == '0)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (cfg_ch0_beats != '0) begin
            state_q <= StStream0;
          end else begin
            state_q <= StStream1;
          end
        end
        StStream0: begin
          if (in_fire) begin
            if (last_beat) begin
              beat_cnt_q <= '0;
              if (ch1_q != '0) begin
                state_q <= StStream1;
              end else if (last_pix) begin
                state_q <= StFlush;
              end else begin
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        StStream1: begin
          if (in_fire) begin
            if (last_beat) begin
              beat_cnt_q <= '0;
              if (last_pix) begin
                state_q <= StFlush;
              end else begin
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                state_q   <= (ch0_q != '0) ? StStream0 : StStream1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        StFlush: begin
          if (!M_Valid) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          if (Control_RE[3:0] == DONE_CODE) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  concat_stream_ctrl_stream_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (load_ok),
    .out_data (M_Data),
    .out_valid(M_Valid),
    .out_ready(M_Ready)
  );

endmodule

// File: tb/tb_concat_stream_ctrl.sv
// Directed bench for concat_stream_ctrl: beat ordering, stalls, degenerate configs, reset and ack.
module tb_concat_stream_ctrl;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   cfg_ch0_beats = '0, cfg_ch1_beats = '0, cfg_height = '0, cfg_width = '0;
  logic [7:0]    Control_RE = '0;
  logic [7:0]    State_RE;
  logic          DMA_Read_Start, DMA_Read_Start_2, DMA_Write_Start;
  logic [DW-1:0] S_Data, S_Data_1, M_Data;
  logic          S_Valid = 1'b1, S_Valid_1 = 1'b1;
  logic          S_Ready, S_Ready_1, M_Valid, M_Ready;
  logic          mready_fix = 1'b1, tog_en = 1'b0, tog = 1'b0;

  int unsigned   a_idx = 0, b_idx = 0;
  logic          clr = 1'b0, a_fire = 1'b0, b_fire = 1'b0;
  logic [15:0]   got[$];
  logic [15:0]   exp_q[$];
  int            a_cnt = 0, b_cnt = 0, d0_cnt = 0, d1_cnt = 0, dw_cnt = 0;
  int            both_rdy = 0, s1_seen = 0;
  logic          stall_chk = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            n_cmp = 0, n_bad = 0;

  assign M_Ready  = tog_en ? tog : mready_fix;
  assign S_Data   = DW'(32'hA000 | a_idx);
  assign S_Data_1 = DW'(32'hB000 | b_idx);

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  concat_stream_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_ch0_beats   (cfg_ch0_beats),
    .cfg_ch1_beats   (cfg_ch1_beats),
    .cfg_height      (cfg_height),
    .cfg_width       (cfg_width),
    .Control_RE      (Control_RE),
    .State_RE        (State_RE),
    .DMA_Read_Start  (DMA_Read_Start),
    .DMA_Read_Start_2(DMA_Read_Start_2),
    .DMA_Write_Start (DMA_Write_Start),
    .S_Data          (S_Data),
    .S_Valid         (S_Valid),
    .S_Ready         (S_Ready),
    .S_Data_1        (S_Data_1),
    .S_Valid_1       (S_Valid_1),
    .S_Ready_1       (S_Ready_1),
    .M_Data          (M_Data),
    .M_Valid         (M_Valid),
    .M_Ready         (M_Ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sources advance only on handshakes seen at the preceding negedge.
  always @(posedge clk) begin
    if (clr) begin
      a_idx <= 0;
      b_idx <= 0;
    end else begin
      if (a_fire) a_idx <= a_idx + 1;
      if (b_fire) b_idx <= b_idx + 1;
    end
  end

  always @(negedge clk) begin
    a_fire = S_Valid && S_Ready;
    b_fire = S_Valid_1 && S_Ready_1;
    if (clr) begin
      a_cnt = 0; b_cnt = 0; d0_cnt = 0; d1_cnt = 0; dw_cnt = 0; s1_seen = 0;
      got.delete();
      prev_stall = 1'b0;
    end else begin
      if (a_fire) a_cnt++;
      if (b_fire) b_cnt++;
      if (DMA_Read_Start) d0_cnt++;
      if (DMA_Read_Start_2) d1_cnt++;
      if (DMA_Write_Start) dw_cnt++;
      if (S_Ready_1) s1_seen++;
      if (S_Ready && S_Ready_1) both_rdy++;
      if (M_Valid && M_Ready) got.push_back(M_Data[15:0]);
      if (stall_chk && prev_stall) begin
        check_eq("stall_valid", 32'(M_Valid), 32'd1);
        check_eq("stall_data", M_Data[31:0], prev_data[31:0]);
      end
      prev_stall = M_Valid && !M_Ready;
      prev_data  = M_Data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int c0, input int c1, input int h, input int w);
    cfg_ch0_beats = 12'(c0);
    cfg_ch1_beats = 12'(c1);
    cfg_height    = 12'(h);
    cfg_width     = 12'(w);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (State_RE == 8'h0F) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic ack(input string tag);
    tick();
    Control_RE = 8'h0F;
    tick();
    Control_RE = 8'h00;
    @(negedge clk);
    check_eq(tag, 32'(State_RE), 32'h00);
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check_eq(tag, 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic check_dma(input string tag);
    check_eq({tag, "_dma0"}, 32'(d0_cnt), 32'd1);
    check_eq({tag, "_dma1"}, 32'(d1_cnt), 32'd1);
    check_eq({tag, "_dmaw"}, 32'(dw_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_q = '{16'hA000, 16'hA001, 16'hB000, 16'hA002, 16'hA003, 16'hB001};
    tick();
    tick();
    check_eq("rst_outs", 32'({State_RE, DMA_Read_Start, DMA_Read_Start_2, DMA_Write_Start,
                              S_Ready, S_Ready_1, M_Valid}), 32'd0);
    rst = 1'b1;
    tick();

    // 1: basic interleave at full throughput
    start_op(2, 1, 1, 2);
    wait_done("t1_done");
    check_eq("t1_mvalid_at_done", 32'(M_Valid), 32'd0);
    check_seq("t1_seq");
    check_dma("t1");
    ack("t1_ack");

    // 2: downstream stalls every other cycle
    tog_en = 1'b1;
    stall_chk = 1'b1;
    start_op(2, 1, 1, 2);
    wait_done("t2_done");
    check_seq("t2_seq");
    stall_chk = 1'b0;
    tog_en = 1'b0;
    ack("t2_ack");

    // 3: ch1 empty, three pixels from stream 0 only
    exp_q = '{16'hA000, 16'hA001, 16'hA002};
    start_op(1, 0, 1, 3);
    wait_done("t3_done");
    check_seq("t3_seq");
    check_eq("t3_b_cnt", 32'(b_cnt), 32'd0);
    check_eq("t3_s1_seen", 32'(s1_seen), 32'd0);
    ack("t3_ack");

    // 4: zero height goes straight to done
    exp_q = {};
    start_op(2, 1, 0, 5);
    wait_done("t4_done");
    check_seq("t4_seq");
    check_eq("t4_a_cnt", 32'(a_cnt), 32'd0);
    check_eq("t4_b_cnt", 32'(b_cnt), 32'd0);
    check_dma("t4");
    ack("t4_ack");

    // 5: reset while streaming from input 1, then a clean rerun
    exp_q = '{16'hA000, 16'hA001, 16'hB000, 16'hA002, 16'hA003, 16'hB001};
    start_op(2, 1, 1, 2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (S_Ready_1) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("t5_reach_s1", 32'(seen), 32'd1);
    end
    rst = 1'b0;
    #1;
    check_eq("t5_rst_outs", 32'({State_RE, DMA_Read_Start, DMA_Read_Start_2, DMA_Write_Start,
                                 S_Ready, S_Ready_1, M_Valid}), 32'd0);
    check_eq("t5_rst_mdata", M_Data[31:0], 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    start_op(2, 1, 1, 2);
    wait_done("t5_done");
    check_seq("t5_seq");
    ack("t5_ack");

    // 6: spurious start and early ack are ignored
    start_op(2, 1, 1, 2);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (S_Ready) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("t6_reach_s0", 32'(seen), 32'd1);
    end
    tick();
    start = 1'b1;
    Control_RE = 8'h0F;
    tick();
    start = 1'b0;
    Control_RE = 8'h00;
    wait_done("t6_done");
    check_seq("t6_seq");
    check_dma("t6");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t6_hold", 32'(State_RE), 32'h0F);
    end
    ack("t6_ack");

    check_eq("never_both_ready", 32'(both_rdy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
